// File: rtl/aes_encipher_datapath_if.sv
// rtl/aes_encipher_datapath_if.sv - start/result, round-key and S-box lanes of the AES encipher datapath
interface aes_encipher_datapath_if #(
  parameter int SBOX_WORDS = 1
);
  logic                      next;
  logic [1:0]                keylen;
  logic [127:0]              block;
  logic [127:0]              new_block;
  logic                      ready;
  logic [3:0]                round;
  logic [127:0]              round_key;
  logic [32*SBOX_WORDS-1:0]  sboxw;
  logic [32*SBOX_WORDS-1:0]  new_sboxw;

  modport master (
    output next, keylen, block, round_key, new_sboxw,
    input  new_block, ready, round, sboxw
  );

  modport slave (
    input  next, keylen, block, round_key, new_sboxw,
    output new_block, ready, round, sboxw
  );
endinterface

// File: rtl/aes_encipher_datapath.sv
// rtl/aes_encipher_datapath.sv - iterative AES encipher datapath using external S-boxes and round keys
// One INIT cycle, then per round 4/SBOX_WORDS substitution cycles followed by one MIX cycle.
module aes_encipher_datapath #(
  parameter int SBOX_WORDS = 1
) (
  input  logic clk,
  input  logic reset,
  aes_encipher_datapath_if.slave bus
);

  localparam logic [1:0] WORD_STEP = 2'(SBOX_WORDS % 4);
  localparam logic [1:0] LAST_WORD = 2'(4 - SBOX_WORDS);

  typedef enum logic [1:0] {IDLE, INIT, SBOX, MIX} state_t;

  state_t                   state, state_nxt;
  logic [3:0]               round_ctr, round_nxt;
  logic [1:0]               word_ctr, word_nxt;
  logic [1:0]               keylen_reg, keylen_nxt;
  logic [127:0]             data_reg, data_nxt;
  logic                     ready_reg, ready_nxt;
  logic [32*SBOX_WORDS-1:0] sboxw_c;
  logic [3:0]               nr;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_word(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte (row r, column c) sits at bit 127-8*(4c+r); row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_word(s[127:96]), mix_word(s[95:64]),
            mix_word(s[63:32]),  mix_word(s[31:0])};
  endfunction

  always_comb begin
    case (keylen_reg)
      2'b01:   nr = 4'd14;
      2'b10:   nr = 4'd12;
      default: nr = 4'd10;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    round_nxt  = round_ctr;
    word_nxt   = word_ctr;
    keylen_nxt = keylen_reg;
    data_nxt   = data_reg;
    ready_nxt  = ready_reg;
    sboxw_c    = '0;

    case (state)
      IDLE: begin
        if (bus.next) begin
          data_nxt   = bus.block;
          keylen_nxt = bus.keylen;
          round_nxt  = 4'd0;
          ready_nxt  = 1'b0;
          state_nxt  = INIT;
        end
      end

      INIT: begin
        data_nxt  = data_reg ^ bus.round_key;
        round_nxt = 4'd1;
        state_nxt = SBOX;
      end

      SBOX: begin
        // Lane 0 (MSB lane) carries the lowest word index of this group.
        for (int l = 0; l < SBOX_WORDS; l++) begin
          sboxw_c[32*(SBOX_WORDS-1-l) +: 32] =
            data_reg[32*(3-((int'(word_ctr)+l)%4)) +: 32];
          data_nxt[32*(3-((int'(word_ctr)+l)%4)) +: 32] =
            bus.new_sboxw[32*(SBOX_WORDS-1-l) +: 32];
        end
        if (word_ctr == LAST_WORD) begin
          word_nxt  = 2'd0;
          state_nxt = MIX;
        end else begin
          word_nxt = word_ctr + WORD_STEP;
        end
      end

      MIX: begin
        if (round_ctr == nr) begin
          data_nxt  = shift_rows(data_reg) ^ bus.round_key;
          ready_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          data_nxt  = mix_columns(shift_rows(data_reg)) ^ bus.round_key;
          round_nxt = round_ctr + 4'd1;
          state_nxt = SBOX;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      round_ctr  <= 4'd0;
      word_ctr   <= 2'd0;
      keylen_reg <= 2'b00;
      data_reg   <= '0;
      ready_reg  <= 1'b1;
    end else begin
      state      <= state_nxt;
      round_ctr  <= round_nxt;
      word_ctr   <= word_nxt;
      keylen_reg <= keylen_nxt;
      data_reg   <= data_nxt;
      ready_reg  <= ready_nxt;
    end
  end

  assign bus.round     = round_ctr;
  assign bus.sboxw     = sboxw_c;
  assign bus.new_block = data_reg;
  assign bus.ready     = ready_reg;

endmodule

// File: tb/tb_aes_encipher_datapath.sv
// tb/tb_aes_encipher_datapath.sv - random and known-answer bench for three SBOX_WORDS variants
// A byte-array AES model predicts ready, round, idle result and sboxw quiet cycles every cycle.
module tb_aes_encipher_datapath;

  localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
  localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         next = 1'b0;
  logic [1:0]   keylen = 2'b00;
  logic [127:0] block = '0;
  logic [127:0] rk [0:15];
  int           vectors = 0;
  int           miscompares = 0;
  int           lat [3];

  logic         rdy [3];
  logic [127:0] nb  [3];
  logic [3:0]   rnd [3];
  logic [127:0] sbw [3];

  always #5 clk = ~clk;

  function automatic int sw_of(input int k);
    return 1 << k;
  endfunction

  function automatic int nk_of(input logic [1:0] kl);
    case (kl)
      2'b01:   return 8;
      2'b10:   return 6;
      default: return 4;
    endcase
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254, followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, base;
    int e;
    inv = 8'h01;
    base = x;
    e = 254;
    while (e != 0) begin
      if (e[0]) inv = gmul(inv, base);
      base = gmul(base, base);
      e = e >> 1;
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub128(input logic [127:0] v);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(v[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [7:0] rcon(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 1; i < n; i++) r = gmul(r, 8'h02);
    return r;
  endfunction

  task automatic set_keys(input logic [255:0] key, input int nk);
    logic [31:0] w [0:63];
    logic [31:0] t;
    int nr;
    nr = nk + 6;
    for (int i = 0; i < 64; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) t = 32'(sub128({96'b0, t[23:0], t[31:24]})) ^ {rcon(i/nk), 24'h0};
      else if (nk > 6 && i % nk == 4) t = 32'(sub128({96'b0, t}));
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  function automatic logic [127:0] ref_cipher(input logic [127:0] p, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox(s[i]);
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[row+4*c] = s[row+4*((c+row)%4)];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic void chk(input string name, input int k,
                              input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s sbox_words=%0d got=%h expected=%h", name, sw_of(k), act, exp);
    end
  endfunction

  aes_encipher_datapath_if #(.SBOX_WORDS(1)) bus1 ();
  aes_encipher_datapath_if #(.SBOX_WORDS(2)) bus2 ();
  aes_encipher_datapath_if #(.SBOX_WORDS(4)) bus4 ();

  aes_encipher_datapath #(.SBOX_WORDS(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  aes_encipher_datapath #(.SBOX_WORDS(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));
  aes_encipher_datapath #(.SBOX_WORDS(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

  assign bus1.next = next;
  assign bus2.next = next;
  assign bus4.next = next;
  assign bus1.keylen = keylen;
  assign bus2.keylen = keylen;
  assign bus4.keylen = keylen;
  assign bus1.block = block;
  assign bus2.block = block;
  assign bus4.block = block;
  assign bus1.round_key = rk[bus1.round];
  assign bus2.round_key = rk[bus2.round];
  assign bus4.round_key = rk[bus4.round];
  assign bus1.new_sboxw = 32'(sub128({96'b0, bus1.sboxw}));
  assign bus2.new_sboxw = 64'(sub128({64'b0, bus2.sboxw}));
  assign bus4.new_sboxw = sub128(bus4.sboxw);

  assign rdy[0] = bus1.ready;
  assign rdy[1] = bus2.ready;
  assign rdy[2] = bus4.ready;
  assign nb[0]  = bus1.new_block;
  assign nb[1]  = bus2.new_block;
  assign nb[2]  = bus4.new_block;
  assign rnd[0] = bus1.round;
  assign rnd[1] = bus2.round;
  assign rnd[2] = bus4.round;
  assign sbw[0] = {96'b0, bus1.sboxw};
  assign sbw[1] = {64'b0, bus2.sboxw};
  assign sbw[2] = bus4.sboxw;

  // Model state per variant: edges since the accepting edge, and the predicted result.
  initial begin : compare
    bit           busy [3];
    int           j [3];
    int           nr [3];
    logic [127:0] exp_ct [3];
    logic [127:0] last_ct [3];
    logic [3:0]   exp_rnd [3];
    int           s;
    for (int k = 0; k < 3; k++) begin
      busy[k] = 1'b0; j[k] = 0; nr[k] = 10;
      exp_ct[k] = '0; last_ct[k] = '0; exp_rnd[k] = 4'd0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        s = 4 / sw_of(k);
        if (reset) begin
          busy[k] = 1'b0; last_ct[k] = '0; exp_rnd[k] = 4'd0;
        end
        chk("ready", k, {127'b0, rdy[k]}, {127'b0, !busy[k]});
        chk("round", k, {124'b0, rnd[k]}, {124'b0, exp_rnd[k]});
        if (!busy[k]) chk("new_block_idle", k, nb[k], last_ct[k]);
        if (!(busy[k] && j[k] >= 1 && ((j[k]-1) % (s+1)) < s))
          chk("sboxw_quiet", k, sbw[k], '0);
        if (!reset) begin
          if (busy[k]) begin
            j[k]++;
            if (j[k] == 1 + nr[k]*(s+1)) begin
              busy[k] = 1'b0; last_ct[k] = exp_ct[k]; exp_rnd[k] = 4'(nr[k]);
            end else begin
              exp_rnd[k] = 4'(1 + (j[k]-1)/(s+1));
            end
          end else if (next) begin
            busy[k] = 1'b1; j[k] = 0; nr[k] = nk_of(keylen) + 6;
            exp_ct[k] = ref_cipher(block, nr[k]); exp_rnd[k] = 4'd0;
          end
        end
      end
    end
  end

  task automatic start_op(input logic [255:0] key, input logic [1:0] kl, input logic [127:0] p);
    set_keys(key, nk_of(kl));
    keylen = kl;
    block = p;
    next = 1'b1;
    @(posedge clk); #1;
    next = 1'b0;
  endtask

  task automatic wait_done(input int already);
    bit done;
    for (int k = 0; k < 3; k++) lat[k] = 0;
    for (int c = already + 1; c <= already + 300; c++) begin
      @(posedge clk); #1;
      done = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (lat[k] == 0 && rdy[k]) lat[k] = c;
        if (lat[k] == 0) done = 1'b0;
      end
      if (done) break;
    end
    for (int k = 0; k < 3; k++) begin
      if (lat[k] == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL ready_timeout sbox_words=%0d", sw_of(k));
      end
    end
  endtask

  task automatic check_kat(input string name, input logic [127:0] ct,
                           input int l1, input int l2, input int l4);
    for (int k = 0; k < 3; k++) begin
      chk(name, k, nb[k], ct);
      chk({name, "_latency"}, k, 128'(lat[k]), 128'((k == 0) ? l1 : (k == 1) ? l2 : l4));
    end
  endtask

  initial begin : stim
    logic [255:0] key;
    logic [1:0]   kl;
    logic [127:0] p;

    for (int r = 0; r < 16; r++) rk[r] = '0;
    chk("pin_sbox_00", 0, 128'(sbox(8'h00)), 128'h63);
    chk("pin_sbox_53", 0, 128'(sbox(8'h53)), 128'hed);
    set_keys(K128, 4);
    chk("pin_ref_aes128", 0, ref_cipher(PT, 10), CT128);
    set_keys(K192, 6);
    chk("pin_ref_aes192", 0, ref_cipher(PT, 12), CT192);
    set_keys(K256, 8);
    chk("pin_ref_aes256", 0, ref_cipher(PT, 14), CT256);

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_ready", k, {127'b0, rdy[k]}, 128'd1);
      chk("reset_new_block", k, nb[k], '0);
    end
    reset = 1'b0;

    start_op(K128, 2'b00, PT); wait_done(0); check_kat("aes128", CT128, 51, 31, 21);
    start_op(K256, 2'b01, PT); wait_done(0); check_kat("aes256", CT256, 71, 43, 29);
    start_op(K192, 2'b10, PT); wait_done(0); check_kat("aes192", CT192, 61, 37, 25);
    start_op(K128, 2'b11, PT); wait_done(0); check_kat("keylen_11", CT128, 51, 31, 21);

    // Second start five cycles in, with keylen and block changed underneath.
    start_op(K128, 2'b00, PT);
    repeat (4) begin @(posedge clk); #1; end
    next = 1'b1; keylen = 2'b01; block = ~PT;
    @(posedge clk); #1;
    next = 1'b0;
    wait_done(5);
    check_kat("ignored_next", CT128, 51, 31, 21);

    // Start request on the very edge where the 4-lane variant finishes.
    start_op(K128, 2'b00, PT);
    repeat (20) begin @(posedge clk); #1; end
    next = 1'b1;
    @(posedge clk); #1;
    next = 1'b0;
    chk("same_edge_next_ready", 2, {127'b0, rdy[2]}, 128'd1);
    wait_done(21);
    for (int k = 0; k < 3; k++) chk("same_edge_next_result", k, nb[k], CT128);

    // Asynchronous reset mid-operation, then restart on the first edge after release.
    start_op(K128, 2'b00, PT);
    repeat (19) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("abort_ready", k, {127'b0, rdy[k]}, 128'd1);
      chk("abort_new_block", k, nb[k], '0);
      chk("abort_round", k, {124'b0, rnd[k]}, '0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    start_op(K128, 2'b00, PT); wait_done(0); check_kat("after_reset", CT128, 51, 31, 21);

    for (int n = 0; n < 12; n++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
      kl = 2'($urandom_range(0, 3));
      p = {$urandom(), $urandom(), $urandom(), $urandom()};
      start_op(key, kl, p);
      wait_done(0);
      for (int k = 0; k < 3; k++)
        chk("random_latency", k, 128'(lat[k]), 128'(1 + (nk_of(kl) + 6) * (4 / sw_of(k) + 1)));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_encipher_datapath.md
AES_ENCIPHER_DATAPATH -- requirements
Module: aes_encipher_datapath

Interface
REQ-001 SHALL have parameter SBOX_WORDS, default 1, meaning the number of 32-bit S-box words substituted per cycle; legal values are 1, 2 and 4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on the rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port next, input, 1, a single-cycle pulse that starts encipherment of block.
REQ-005 SHALL have port keylen, input, 2, key length: 00=AES-128 (Nr=10), 01=AES-256 (Nr=14), 10=AES-192 (Nr=12), 11=treated as 00.
REQ-006 SHALL have port round, output, 4, the index of the round key requested.
REQ-007 SHALL have port round_key, input, 128, the round key for index round, supplied combinationally in the same cycle.
REQ-008 SHALL have port sboxw, output, 32*SBOX_WORDS, the state words presented to external S-boxes.
REQ-009 SHALL have port new_sboxw, input, 32*SBOX_WORDS, the substituted words, returned combinationally in the same cycle.
REQ-010 SHALL have port block, input, 128, the plaintext; word w0=[127:96] and w3=[31:0].
REQ-011 SHALL have port new_block, output, 128, the state register (the ciphertext once ready has risen).
REQ-012 SHALL have port ready, output, 1, high when idle and the result is valid.

Function
REQ-013 SHALL implement states IDLE, INIT, SBOX, MIX.
REQ-014 SHALL, in IDLE with next=1: capture block and keylen, clear the round counter to 0, drop ready and enter INIT.
REQ-015 SHALL ignore next whenever the state is not IDLE; the captured keylen is held until the operation completes.
REQ-016 SHALL, in INIT (round=0), load state = block ^ round_key, set the round counter to 1 and enter SBOX; INIT lasts one cycle.
REQ-017 SHALL, in SBOX, use a word counter that steps by SBOX_WORDS per cycle from 0 through 3.
REQ-018 SHALL, in each SBOX cycle, drive sboxw with words ctr..ctr+SBOX_WORDS-1, lowest word index in the most significant lane.
REQ-019 SHALL write new_sboxw back into the same word positions of the state.
REQ-020 SHALL leave SBOX for MIX after 4/SBOX_WORDS cycles and reset the word counter to 0.
REQ-021 SHALL, in MIX with round<Nr, set state = AddRoundKey(MixColumns(ShiftRows(state))); MixColumns uses the GF(2^8) polynomial 0x11b.
REQ-022 SHALL then increment round and return to SBOX.
REQ-023 SHALL, in MIX with round=Nr, set state = AddRoundKey(ShiftRows(state)) with no MixColumns, raise ready and enter IDLE.
REQ-024 SHALL have a latency from the next cycle to ready=1 of 1 + Nr*(4/SBOX_WORDS + 1) cycles:
 - SBOX_WORDS=1, AES-128: 51 cycles
 - SBOX_WORDS=1, AES-256: 71 cycles
 - SBOX_WORDS=4, AES-128: 21 cycles
REQ-025 SHALL hold new_block and ready stable in IDLE until the next accepted next.
REQ-026 SHALL drive round from the round counter at all times, with a range of 0..Nr.
REQ-027 SHALL drive sboxw to 0 outside SBOX.
REQ-028 SHALL treat a back-to-back next in the same cycle that ready rises as not accepted; a start is accepted only in IDLE from the following cycle.

Reset
REQ-029 SHALL, on reset assertion and independent of clk, immediately go to state IDLE with:
 - ready=1
 - new_block=0
 - round=0
 - word counter=0
 - captured keylen=00
REQ-030 SHALL abort any operation in progress when reset is asserted mid-operation; no partial result remains visible.
REQ-031 SHALL accept next in the first clock edge after reset deasserts.

Verification
REQ-032 SHALL pass this check: AES-128, SBOX_WORDS=1, key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff -> new_block 69c4e0d86a7b0430d8cdb78070b4c55a with ready rising exactly 51 cycles after next.
REQ-033 SHALL pass this check: AES-256, key 00..1f, same block -> 8ea2b7ca516745bfeafc49904b496089 after 71 cycles; then AES-192, key 00..17 -> dda97ca4864cdfe06eaf70a0ec0d7191 after 61 cycles.
REQ-034 SHALL pass this check: the vectors of REQ-032 and REQ-033 with SBOX_WORDS=2 and 4 -> identical ciphertexts with latencies 31 and 21 (AES-128).
REQ-035 SHALL pass this check: next pulsed again 5 cycles after start -> ignored; the first result is unchanged; keylen changed mid-operation has no effect.
REQ-036 SHALL pass this check: reset asserted at cycle 20 of an AES-128 operation -> same cycle: ready=1, new_block=0; a new operation after release yields the correct ciphertext.
REQ-037 SHALL pass this check: keylen=11 -> result and latency identical to keylen=00.
